// File: rtl/pass_guard_pkg.sv
// Shared definitions for the password guard: FSM state codes, digit width and a small helper.
package pass_guard_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_OPEN  = 2'd2;
   localparam logic [1:0] ST_ALARM = 2'd3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mod_sec_timer.sv
// Restartable cycle counter; done pulses for one cycle when the count reaches limit-1.
module mod_sec_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] limit,
   output logic         done
);

   logic [W-1:0] count_reg;
   logic         running_reg;

   // Counting stops at terminal count, so done cannot repeat without a new start.
   assign done = running_reg && (count_reg == limit - W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg   <= '0;
         running_reg <= 1'b0;
      end else if (start) begin
         count_reg   <= '0;
         running_reg <= 1'b1;
      end else if (done) begin
         count_reg   <= '0;
         running_reg <= 1'b0;
      end else if (running_reg) begin
         count_reg   <= count_reg + W'(1);
      end
   end

endmodule

// File: rtl/mod_pass_guard.sv
// Keypad password controller with failure counting and timed alarm.
// Define PASS_GUARD_RELOCK_EN to make OPEN relock automatically after OPEN_SECS.
module mod_pass_guard
   import pass_guard_pkg::*;
#(
   parameter int          CLK_FREQ   = 50_000_000,
   parameter int          PASS_LEN   = 4,
   parameter logic [31:0] PASSWORD   = 32'h0000_1234,
   parameter int          MAX_FAILS  = 3,
   parameter int          ALARM_SECS = 10,
   parameter int          OPEN_SECS  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               digit_valid,
   input  logic               enter,
   input  logic               clear,
   input  logic               lock,
   output logic               unlocked,
   output logic               bad_pulse,
   output logic               alarm,
   output logic [2:0]         fail_cnt
);

   localparam int BUF_W = DIGIT_W * PASS_LEN;
   localparam int CNT_W = $clog2(PASS_LEN + 1);
   localparam int TMR_W = $clog2(max_int(ALARM_SECS, OPEN_SECS) * CLK_FREQ + 1);
   localparam logic [CNT_W-1:0] PASS_LEN_C = CNT_W'(PASS_LEN);
   localparam logic [TMR_W-1:0] ALARM_N    = TMR_W'(ALARM_SECS * CLK_FREQ);
`ifdef PASS_GUARD_RELOCK_EN
   localparam logic [TMR_W-1:0] OPEN_N     = TMR_W'(OPEN_SECS * CLK_FREQ);
`endif

   logic [1:0]       state_reg, state_next;
   logic [BUF_W-1:0] buffer_reg, buffer_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             overflow_reg, overflow_next;
   logic [2:0]       fail_reg, fail_next;
   logic             bad_reg, bad_next;
   logic             match;
   logic             tmr_start, tmr_stop, tmr_done;
   logic [TMR_W-1:0] tmr_limit;

`ifdef PASS_GUARD_RELOCK_EN
   assign tmr_limit = (state_reg == ST_OPEN) ? OPEN_N : ALARM_N;
`else
   assign tmr_limit = ALARM_N;
`endif

   mod_sec_timer #(.W(TMR_W)) u_timer (
      .clk   (clk),
      .rst   (rst | tmr_stop),
      .start (tmr_start),
      .limit (tmr_limit),
      .done  (tmr_done)
   );

   // A short or overflowed entry never matches, even if its buffer bits happen to agree.
   assign match = (count_reg == PASS_LEN_C) && !overflow_reg &&
                  (buffer_reg == PASSWORD[BUF_W-1:0]);

   always_comb begin
      state_next    = state_reg;
      buffer_next   = buffer_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      fail_next     = fail_reg;
      bad_next      = 1'b0;
      tmr_start     = 1'b0;
      tmr_stop      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (clear) begin
               buffer_next   = '0;
               count_next    = '0;
               overflow_next = 1'b0;
            end else if (enter) begin
               state_next = ST_CHECK;
            end else if (digit_valid) begin
               if (count_reg < PASS_LEN_C) begin
                  buffer_next = BUF_W'({buffer_reg, digit});
                  count_next  = count_reg + CNT_W'(1);
               end else begin
                  overflow_next = 1'b1;
               end
            end
         end
         ST_CHECK: begin
            buffer_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            if (match) begin
               state_next = ST_OPEN;
               fail_next  = '0;
`ifdef PASS_GUARD_RELOCK_EN
               tmr_start  = 1'b1;
`endif
            end else if ((fail_reg + 3'd1) == 3'(MAX_FAILS)) begin
               state_next = ST_ALARM;
               fail_next  = 3'(MAX_FAILS);
               tmr_start  = 1'b1;
            end else begin
               state_next = ST_IDLE;
               fail_next  = fail_reg + 3'd1;
               bad_next   = 1'b1;
            end
         end
         ST_OPEN: begin
            if (lock) begin
               state_next = ST_IDLE;
`ifdef PASS_GUARD_RELOCK_EN
               tmr_stop   = 1'b1;
            end else if (tmr_done) begin
               state_next = ST_IDLE;
`endif
            end
         end
         default: begin
            if (tmr_done) begin
               state_next = ST_IDLE;
               fail_next  = '0;
            end
         end
      endcase
   end

   // Outputs are a registered view of the core, one edge behind the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         buffer_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         fail_reg     <= '0;
         bad_reg      <= 1'b0;
         unlocked     <= 1'b0;
         alarm        <= 1'b0;
         bad_pulse    <= 1'b0;
         fail_cnt     <= '0;
      end else begin
         state_reg    <= state_next;
         buffer_reg   <= buffer_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
         fail_reg     <= fail_next;
         bad_reg      <= bad_next;
         unlocked     <= (state_reg == ST_OPEN);
         alarm        <= (state_reg == ST_ALARM);
         bad_pulse    <= bad_reg;
         fail_cnt     <= fail_reg;
      end
   end

endmodule

// File: tb/tb_mod_pass_guard.sv
// Randomized and directed bench for mod_pass_guard against a queue-based behavioural model.
module tb_mod_pass_guard;

   localparam int CLK_FREQ   = 10;
   localparam int PASS_LEN   = 4;
   localparam int PASSWORD   = 'h1234;
   localparam int MAX_FAILS  = 3;
   localparam int ALARM_CYC  = 2 * CLK_FREQ;
`ifdef PASS_GUARD_RELOCK_EN
   localparam int OPEN_CYC   = 3 * CLK_FREQ;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       digit_valid = 1'b0, enter = 1'b0, clear = 1'b0, lock = 1'b0;
   logic       unlocked, bad_pulse, alarm;
   logic [2:0] fail_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mod_pass_guard #(
      .CLK_FREQ(CLK_FREQ), .PASS_LEN(PASS_LEN), .PASSWORD(32'h1234),
      .MAX_FAILS(MAX_FAILS), .ALARM_SECS(2), .OPEN_SECS(3)
   ) dut (
      .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid), .enter(enter),
      .clear(clear), .lock(lock), .unlocked(unlocked), .bad_pulse(bad_pulse),
      .alarm(alarm), .fail_cnt(fail_cnt)
   );

   // Behavioural model: entered digits as a queue, alarm/open as remaining-cycle counts.
   int m_digits[$];
   bit m_over, m_pending, m_open, m_bad;
   int m_fails, m_alarm_left;
`ifdef PASS_GUARD_RELOCK_EN
   int m_open_left;
`endif
   bit e_unl, e_alarm, e_bad;
   int e_fail;

   task automatic model_edge(input bit r, input bit dv, input int d, input bit en,
                             input bit cl, input bit lk);
      int v;
      bit ok;
      if (r) begin
         m_digits.delete();
         m_over = 0; m_pending = 0; m_open = 0; m_bad = 0; m_fails = 0; m_alarm_left = 0;
         e_unl = 0; e_alarm = 0; e_bad = 0; e_fail = 0;
         return;
      end
      e_unl = m_open; e_alarm = (m_alarm_left > 0); e_bad = m_bad; e_fail = m_fails;
      m_bad = 0;
      if (m_alarm_left > 0) begin
         m_alarm_left--;
         if (m_alarm_left == 0) m_fails = 0;
      end else if (m_pending) begin
         m_pending = 0;
         v = 0;
         foreach (m_digits[i]) v = v * 16 + m_digits[i];
         ok = (m_digits.size() == PASS_LEN) && !m_over && (v == PASSWORD);
         m_digits.delete();
         m_over = 0;
         if (ok) begin
            m_open = 1; m_fails = 0;
`ifdef PASS_GUARD_RELOCK_EN
            m_open_left = OPEN_CYC;
`endif
         end else if (m_fails + 1 == MAX_FAILS) begin
            m_alarm_left = ALARM_CYC; m_fails = MAX_FAILS;
         end else begin
            m_fails++; m_bad = 1;
         end
      end else if (m_open) begin
         if (lk) m_open = 0;
`ifdef PASS_GUARD_RELOCK_EN
         else begin
            m_open_left--;
            if (m_open_left == 0) m_open = 0;
         end
`endif
      end else if (cl) begin
         m_digits.delete(); m_over = 0;
      end else if (en) begin
         m_pending = 1;
      end else if (dv) begin
         if (m_digits.size() < PASS_LEN) m_digits.push_back(d);
         else m_over = 1;
      end
   endtask

   task automatic step(input bit r, input bit dv, input int d, input bit en,
                       input bit cl, input bit lk);
      @(negedge clk);
      rst = r; digit_valid = dv; digit = 4'(d); enter = en; clear = cl; lock = lk;
      @(posedge clk);
      model_edge(r, dv, d, en, cl, lk);
      #1;
      rst = 0; digit_valid = 0; enter = 0; clear = 0; lock = 0;
   endtask

   task automatic key(input int d);
      step(0, 1, d, 0, 0, 0);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic code(input int a, input int b, input int c, input int d);
      key(a); key(b); key(c); key(d);
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      n_cmp++; if ({unlocked, alarm, bad_pulse} !== 3'b000) begin n_bad++;
         $display("FAIL reset_flags: got %b expected 000", {unlocked, alarm, bad_pulse}); end
      n_cmp++; if (fail_cnt !== 3'd0) begin n_bad++;
         $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
   endtask

   task automatic test_unlock();
      code(1, 2, 3, 4); step(0, 0, 0, 1, 0, 0); idle();
      n_cmp++; if (unlocked !== 1'b0) begin n_bad++;
         $display("FAIL unlock_early: got %b expected 0", unlocked); end
      idle();
      n_cmp++; if (unlocked !== 1'b1 || fail_cnt !== 3'd0) begin n_bad++;
         $display("FAIL unlock: got unl=%b fc=%0d expected unl=1 fc=0", unlocked, fail_cnt); end
      step(0, 0, 0, 0, 0, 1); idle();
      n_cmp++; if (unlocked !== 1'b0) begin n_bad++;
         $display("FAIL relock: got %b expected 0", unlocked); end
   endtask

   task automatic test_alarm();
      int high;
      for (int k = 1; k <= 2; k++) begin
         code(1, 2, 3, 5); step(0, 0, 0, 1, 0, 0); idle(); idle();
         n_cmp++; if (bad_pulse !== 1'b1 || fail_cnt !== 3'(k)) begin n_bad++;
            $display("FAIL bad_pulse_%0d: got bp=%b fc=%0d expected bp=1 fc=%0d", k, bad_pulse, fail_cnt, k); end
         idle();
         n_cmp++; if (bad_pulse !== 1'b0) begin n_bad++;
            $display("FAIL bad_pulse_width_%0d: got %b expected 0", k, bad_pulse); end
      end
      code(1, 2, 3, 5); step(0, 0, 0, 1, 0, 0); idle(); idle();
      n_cmp++; if (alarm !== 1'b1 || bad_pulse !== 1'b0 || fail_cnt !== 3'd3) begin n_bad++;
         $display("FAIL alarm_on: got al=%b bp=%b fc=%0d expected al=1 bp=0 fc=3", alarm, bad_pulse, fail_cnt); end
      high = 1;
      code(1, 2, 3, 4); step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0, 1);
      high += 6;
      for (int i = 0; i < 100 && alarm === 1'b1; i++) begin
         idle();
         if (alarm === 1'b1) high++;
      end
      n_cmp++; if (high !== ALARM_CYC) begin n_bad++;
         $display("FAIL alarm_len: got %0d cycles expected %0d", high, ALARM_CYC); end
      n_cmp++; if (fail_cnt !== 3'd0 || unlocked !== 1'b0) begin n_bad++;
         $display("FAIL alarm_end: got fc=%0d unl=%b expected fc=0 unl=0", fail_cnt, unlocked); end
      code(1, 2, 3, 4); step(0, 0, 0, 1, 0, 0); idle(); idle();
      n_cmp++; if (unlocked !== 1'b1) begin n_bad++;
         $display("FAIL unlock_after_alarm: got %b expected 1", unlocked); end
      step(0, 0, 0, 0, 0, 1); idle();
   endtask

   task automatic test_overflow_clear();
      code(1, 2, 3, 4); key(4); step(0, 0, 0, 1, 0, 0); idle(); idle();
      n_cmp++; if (bad_pulse !== 1'b1 || fail_cnt !== 3'd1) begin n_bad++;
         $display("FAIL overflow: got bp=%b fc=%0d expected bp=1 fc=1", bad_pulse, fail_cnt); end
      key(1); key(2); step(0, 0, 0, 0, 1, 0);
      code(1, 2, 3, 4); step(0, 0, 0, 1, 0, 0); idle(); idle();
      n_cmp++; if (unlocked !== 1'b1 || fail_cnt !== 3'd0) begin n_bad++;
         $display("FAIL clear_then_unlock: got unl=%b fc=%0d expected unl=1 fc=0", unlocked, fail_cnt); end
      step(0, 0, 0, 0, 0, 1); idle();
   endtask

   task automatic test_priority();
      code(1, 2, 3, 4); step(0, 1, 5, 1, 0, 0); idle(); idle();
      n_cmp++; if (unlocked !== 1'b1) begin n_bad++;
         $display("FAIL enter_beats_digit: got %b expected 1", unlocked); end
      step(0, 0, 0, 0, 0, 1); idle();
      key(9); step(0, 0, 0, 1, 1, 0); idle(); idle();
      n_cmp++; if (bad_pulse !== 1'b0 || unlocked !== 1'b0 || fail_cnt !== 3'd0) begin n_bad++;
         $display("FAIL clear_beats_enter: got bp=%b unl=%b fc=%0d expected 0 0 0", bad_pulse, unlocked, fail_cnt); end
      step(0, 0, 0, 1, 0, 0); idle(); idle();
      n_cmp++; if (bad_pulse !== 1'b1 || fail_cnt !== 3'd1) begin n_bad++;
         $display("FAIL empty_entry: got bp=%b fc=%0d expected bp=1 fc=1", bad_pulse, fail_cnt); end
   endtask

   task automatic test_rst_alarm();
      for (int k = 0; k < 3; k++) begin
         key(7); step(0, 0, 0, 1, 0, 0); idle();
      end
      idle(); idle(); idle();
      n_cmp++; if (alarm !== 1'b1) begin n_bad++;
         $display("FAIL pre_rst_alarm: got %b expected 1", alarm); end
      step(1, 0, 0, 0, 0, 0);
      n_cmp++; if (alarm !== 1'b0 || fail_cnt !== 3'd0) begin n_bad++;
         $display("FAIL rst_mid_alarm: got al=%b fc=%0d expected al=0 fc=0", alarm, fail_cnt); end
      idle();
      n_cmp++; if (alarm !== 1'b0) begin n_bad++;
         $display("FAIL rst_alarm_stays_off: got %b expected 0", alarm); end
   endtask

   task automatic test_open_timeout();
      int high;
      code(1, 2, 3, 4); step(0, 0, 0, 1, 0, 0); idle(); idle();
      high = (unlocked === 1'b1) ? 1 : 0;
      for (int i = 0; i < 60 && unlocked === 1'b1; i++) begin
         idle();
         if (unlocked === 1'b1) high++;
      end
`ifdef PASS_GUARD_RELOCK_EN
      n_cmp++; if (high !== OPEN_CYC) begin n_bad++;
         $display("FAIL auto_relock: got %0d cycles expected %0d", high, OPEN_CYC); end
`else
      n_cmp++; if (high !== 61) begin n_bad++;
         $display("FAIL open_hold: got %0d cycles expected 61", high); end
      step(0, 0, 0, 0, 0, 1); idle();
`endif
   endtask

   typedef struct packed {
      bit r; bit dv; bit [3:0] d; bit en; bit cl; bit lk;
   } stim_t;

   task automatic test_random();
      stim_t q[$];
      stim_t s;
      int n;
      for (int it = 0; it < 250; it++) begin
         s = '0;
         case ($urandom_range(0, 5))
            0: begin
               for (int i = 1; i <= 4; i++) begin s = '0; s.dv = 1; s.d = 4'(i); q.push_back(s); end
               s = '0; s.en = 1; q.push_back(s);
            end
            1: begin
               n = $urandom_range(0, 5);
               for (int i = 0; i < n; i++) begin
                  s = '0; s.dv = 1; s.d = 4'($urandom_range(1, 5)); q.push_back(s);
               end
               s = '0; s.en = 1; q.push_back(s);
            end
            2: for (int i = 0; i < 4; i++) begin
               s = '0; s.dv = ($urandom_range(0, 1) == 0); s.d = 4'($urandom_range(0, 9));
               s.en = ($urandom_range(0, 3) == 0); s.cl = ($urandom_range(0, 3) == 0);
               s.lk = ($urandom_range(0, 3) == 0); q.push_back(s);
            end
            3: begin s.lk = 1; q.push_back(s); end
            4: begin
               n = $urandom_range(1, 25);
               for (int i = 0; i < n; i++) q.push_back('0);
            end
            default: begin
               if ($urandom_range(0, 9) == 0) s.r = 1; else s.cl = 1;
               q.push_back(s);
            end
         endcase
      end
      foreach (q[i]) begin
         step(q[i].r, q[i].dv, int'(q[i].d), q[i].en, q[i].cl, q[i].lk);
         n_cmp++;
         if (unlocked !== e_unl || alarm !== e_alarm || bad_pulse !== e_bad || fail_cnt !== 3'(e_fail)) begin
            n_bad++;
            $display("FAIL random_step_%0d: got unl=%b al=%b bp=%b fc=%0d expected unl=%b al=%b bp=%b fc=%0d",
                     i, unlocked, alarm, bad_pulse, fail_cnt, e_unl, e_alarm, e_bad, e_fail);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unlock();
      test_alarm();
      test_overflow_clear();
      test_priority();
      test_rst_alarm();
      test_open_timeout();
      step(1, 0, 0, 0, 0, 0);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
